// File: rtl/radix4_seq_multiplier_pkg.sv
// Shared definitions for the radix-4 sequential multiplier: FSM states,
// radix-4 digit values and the digit-counter width helper.
package radix4_seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] DIGIT_0 = 2'd0;
  localparam logic [1:0] DIGIT_1 = 2'd1;
  localparam logic [1:0] DIGIT_2 = 2'd2;
  localparam logic [1:0] DIGIT_3 = 2'd3;

  // Wide enough to count one past the last digit index (SIZE/2).
  function automatic int cnt_width(input int size);
    return $clog2(size / 2) + 1;
  endfunction

endpackage

// File: rtl/radix4_seq_multiplier_digit_mux.sv
// Combinational partial-product generator: product = digit * a, with two
// extra bits so that 3*a is never truncated.
import radix4_seq_multiplier_pkg::*;

module radix4_digit_mux #(
  parameter int SIZE = 16
) (
  input  logic [1:0]      digit,
  input  logic [SIZE-1:0] a,
  output logic [SIZE+1:0] product
);

  logic [SIZE+1:0] a_x1;
  logic [SIZE+1:0] a_x2;

  assign a_x1 = {2'b00, a};
  assign a_x2 = {1'b0, a, 1'b0};

  always_comb begin
    product = '0;
    case (digit)
      DIGIT_0: product = '0;
      DIGIT_1: product = a_x1;
      DIGIT_2: product = a_x2;
      DIGIT_3: product = a_x1 + a_x2;
      default: product = '0;
    endcase
  end

endmodule

// File: rtl/radix4_seq_multiplier.sv
// Unsigned SIZE x SIZE sequential multiplier retiring one radix-4 digit of B
// per cycle. Define EARLY_TERM_EN to finish as soon as the remaining B is zero.
import radix4_seq_multiplier_pkg::*;

module radix4_seq_multiplier #(
  parameter int SIZE = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStart,
  input  logic [SIZE-1:0]   iA,
  input  logic [SIZE-1:0]   iB,
  output logic              oBusy,
  output logic              oDone,
  output logic [2*SIZE-1:0] oOUT
);

  localparam int CW = cnt_width(SIZE);

  state_e              state_q, state_d;
  logic [SIZE-1:0]     a_q, a_d;
  logic [SIZE-1:0]     b_sh_q, b_sh_d;
  logic [2*SIZE-1:0]   acc_q, acc_d;
  logic [2*SIZE-1:0]   out_q, out_d;
  logic [CW-1:0]       k_q, k_d;

  logic [SIZE+1:0]     pp;
  logic [2*SIZE-1:0]   pp_shifted;
  logic [2*SIZE-1:0]   acc_sum;
  logic                run_last;

  radix4_digit_mux #(.SIZE(SIZE)) u_digit_mux (
    .digit   (b_sh_q[1:0]),
    .a       (a_q),
    .product (pp)
  );

  // Digit k carries weight 4^k, i.e. a left shift of 2*k.
  assign pp_shifted = {{(SIZE-2){1'b0}}, pp} << {k_q, 1'b0};
  assign acc_sum    = acc_q + pp_shifted;

`ifdef EARLY_TERM_EN
  assign run_last = ((b_sh_q >> 2) == '0);
`else
  localparam logic [CW-1:0] LAST_K = CW'(SIZE / 2 - 1);
  assign run_last = (k_q == LAST_K);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    out_d   = out_q;
    k_d     = k_q;
    case (state_q)
      IDLE, DONE: begin
        if (iStart) begin
          a_d     = iA;
          b_sh_d  = iB;
          acc_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d  = acc_sum;
        b_sh_d = b_sh_q >> 2;
        k_d    = k_q + CW'(1);
        if (run_last) begin
          out_d   = acc_sum;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      k_q     <= k_d;
    end
  end

  assign oBusy = (state_q == RUN);
  assign oDone = (state_q == DONE);
  assign oOUT  = out_q;

endmodule

// File: doc/radix4_seq_multiplier.md
RADIX4_SEQ_MULTIPLIER -- requirements
Module: radix4_seq_multiplier

Interface
REQ-001 The block SHALL have parameter SIZE, default 16: operand width in bits; legal values are even and >= 4.
REQ-002 The block SHALL have port Clock, input, 1 bit: single clock, all state updated on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port iStart, input, 1 bit: request to begin a multiplication, sampled at a rising edge of Clock.
REQ-005 The block SHALL have port iA, input, SIZE bits: unsigned multiplicand, captured when a start is accepted.
REQ-006 The block SHALL have port iB, input, SIZE bits: unsigned multiplier, captured when a start is accepted.
REQ-007 The block SHALL have port oBusy, output, 1 bit: high while the state is RUN.
REQ-008 The block SHALL have port oDone, output, 1 bit: single-cycle pulse marking that oOUT holds a new product.
REQ-009 The block SHALL have port oOUT, output, 2*SIZE bits: the product, registered.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 A start SHALL be accepted when iStart=1 in IDLE or DONE. On acceptance: latch iA; latch iB into the shift register; clear the accumulator and digit counter k; go to RUN.
REQ-012 iStart SHALL be ignored in RUN; the latched operands SHALL NOT change.
REQ-013 Each RUN cycle SHALL perform these steps:
- take digit d = B_sh[1:0];
- form the partial product P = d*A, exactly 0, A, 2A or 3A, computed SIZE+2 bits wide with no truncation;
- add P << (2*k) to the 2*SIZE-bit accumulator;
- shift B_sh right by 2;
- increment k.
REQ-014 Without early termination, RUN SHALL last exactly SIZE/2 cycles. On the cycle after the last digit the FSM SHALL be in DONE.
REQ-015 In DONE, oDone=1 for one cycle and oOUT = A*B exactly. Next state: RUN if a start is accepted, else IDLE.
REQ-016 oOUT SHALL hold the last product until the next DONE or a Reset; it SHALL NOT show partial sums.
REQ-017 Latency SHALL be fixed: start accepted at edge t gives oDone=1 in the cycle following edge t+SIZE/2.
REQ-018 Back-to-back operation SHALL be supported: a start accepted in DONE begins RUN with no IDLE gap.
REQ-019 The accumulator SHALL never overflow, since the product of two SIZE-bit values fits in 2*SIZE bits.

Reset
REQ-020 When Reset=1 at a clock edge, the block SHALL go to IDLE and clear oBusy, oDone, oOUT, the accumulator, B_sh and k.
REQ-021 Reset during RUN SHALL abort the operation; no oDone SHALL follow.
REQ-022 Reset SHALL take priority over iStart in the same cycle.

Configuration
REQ-023 The macro EARLY_TERM_EN SHALL select early termination at compile time.
REQ-024 With EARLY_TERM_EN defined, RUN SHALL exit to DONE after the first RUN cycle in which B_sh becomes zero after the shift. RUN lasts max(1, index of the highest nonzero radix-4 digit + 1) cycles. The product is identical to REQ-015.
REQ-025 Without EARLY_TERM_EN, the fixed latency of REQ-014 and REQ-017 SHALL apply and the B_sh==0 comparator SHALL be absent.

Structure
REQ-026 A shared package SHALL hold:
- the FSM state encoding constants IDLE, RUN and DONE;
- the radix-4 digit constants;
- the counter-width function clog2(SIZE/2)+1.
REQ-027 The partial-product generator SHALL be a sub-module, radix4_digit_mux: parameter SIZE, inputs digit[1:0] and A, output SIZE+2 bits equal to digit*A. It is purely combinational and instantiated once.

Verification (SIZE=16)
REQ-028 The bench SHALL cover: iA=3, iB=5, start in IDLE -> oDone in the cycle after edge t+8, oOUT=0x0000000F, oBusy high for 8 cycles.
REQ-029 The bench SHALL cover: iA=0xFFFF, iB=0xFFFF -> oOUT=0xFFFE0001; then iA=0, iB=0x1234 -> oOUT=0.
REQ-030 The bench SHALL cover: iStart pulsed at RUN cycle 3 with iA=7, iB=7 -> ignored; the original result is delivered and oDone pulses once.
REQ-031 The bench SHALL cover: Reset at RUN cycle 4 -> the next cycle shows IDLE and oOUT=0, with no oDone pulse; a following start of 2*9 -> oOUT=18.
REQ-032 The bench SHALL cover: back-to-back operation, where a start of 0x00FF*0x0100 is accepted while a prior operation is in DONE -> the second oDone follows 8 RUN cycles later with oOUT=0x0000FF00.
REQ-033 The bench SHALL cover, with EARLY_TERM_EN: iB=1 -> 1 RUN cycle, oOUT=iA; iB=0x0040 -> 4 RUN cycles, oOUT=iA*64; iB=0 -> 1 RUN cycle, oOUT=0.
